mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The parameter list SHALL be: TIMEOUT, 255, max cycles waiting for dmem_ack before abort (range 1..255).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 alu_out  input  32  effective byte address from the execute stage.
REQ-005 Wr_data  input  32  store data from the execute stage.
REQ-006 mem_en  input  1  a memory access is requested this instruction.
REQ-007 mem_we  input  1  1 = store, 0 = load; valid only with mem_en.
REQ-008 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 dmem_req  output  1  data-memory request, held until ack or abort.
REQ-010 dmem_we  output  1  write strobe qualifying dmem_req.
REQ-011 dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-012 dmem_be  output  4  byte enables.
REQ-013 dmem_wdata  output  32  lane-replicated store data.
REQ-014 dmem_rdata  input  32  read data, valid in the dmem_ack cycle.
REQ-015 dmem_ack  input  1  memory completion, one cycle.
REQ-016 load_data  output  32  formatted load result, registered, held until next load completes.
REQ-017 stall  output  1  freeze upstream pipeline.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  one-cycle fault pulse (misaligned, illegal funct3, timeout).

Function
REQ-020 States SHALL be IDLE, BUSY, DONE; 2-bit state register.
REQ-021 IDLE with mem_en=1 and legal, aligned access SHALL latch address, data, funct3, we and enter BUSY; stall=1 combinationally that cycle.
REQ-022 Misaligned = H/HU with addr[0]=1, W with addr[1:0]!=0; illegal = funct3 011/110/111, or 100/101 with mem_we=1.
REQ-023 IDLE with mem_en=1 and misaligned/illegal SHALL pulse err for one cycle, issue no dmem_req, keep stall=0, remain IDLE.
REQ-024 In BUSY dmem_req=1, stall=1, and dmem_addr/be/wdata/we SHALL stay stable until ack or abort.
REQ-025 Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{Wr_data[7:0]}}; SH be=4'b0011<<{addr[1],1'b0}, wdata={2{Wr_data[15:0]}}; SW be=4'b1111, wdata=Wr_data.
REQ-026 Loads SHALL drive dmem_we=0, be=4'b1111.
REQ-027 On dmem_ack in BUSY, a load SHALL register load_data: byte/half selected by addr[1:0]/addr[1], sign-extended for B/H, zero-extended for BU/HU, full word for W; then enter DONE.
REQ-028 On dmem_ack for a store, load_data SHALL be unchanged; enter DONE.
REQ-029 DONE SHALL last exactly one cycle: done=1, stall=0, dmem_req=0, mem_en ignored, next state IDLE.
REQ-030 A BUSY-cycle counter SHALL clear on BUSY entry; if it reaches TIMEOUT with no ack, drop dmem_req, pulse err, leave load_data unchanged, go IDLE with stall=0.
REQ-031 dmem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins, no err).
REQ-032 dmem_ack outside BUSY SHALL be ignored.
REQ-033 Latency: aligned access with ack in first BUSY cycle SHALL give done two cycles after the accepting IDLE edge; stall high for exactly two cycles.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, counter 0, and all outputs (dmem_*, load_data, stall, done, err) to 0, including mid-BUSY (dmem_req drops without waiting for clk).
REQ-035 After rst deasserts, first access SHALL be accepted at the next rising clk edge with mem_en=1.

Verification
REQ-036 LB addr 0x1003, rdata 0x80FF_1234, ack in 1st BUSY cycle -> load_data 0xFFFF_FF80, done pulse, stall 2 cycles.
REQ-037 LHU addr 0x2002, rdata 0xBEEF_0000 -> load_data 0x0000_BEEF, err=0.
REQ-038 SB addr 0x3001, Wr_data 0x0000_00A5 -> dmem_be 4'b0010, dmem_wdata 0xA5A5_A5A5, dmem_we=1, dmem_addr 0x3000.
REQ-039 LW addr 0x4002 -> err one cycle, no dmem_req, stall 0; same for funct3=011.
REQ-040 TIMEOUT=4, no ack -> dmem_req high 4 cycles then low, err pulse, load_data unchanged; repeat with ack on 4th cycle -> done, no err.
REQ-041 rst asserted mid-BUSY between edges -> dmem_req, stall 0 immediately; next access proceeds normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a request/ack data memory.
// Formats store lanes and load results, and times out if the memory never answers.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out,
    input  logic [31:0] Wr_data,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q, load_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [2:0]  f3_q;

    logic        misaligned, illegal, accept, busy;
    logic        stall_c, err_c, done_c;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, load_fmt;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            3'b000: ;
            3'b001: misaligned = alu_out[0];
            3'b010: misaligned = |alu_out[1:0];
            3'b100: illegal = mem_we;
            3'b101: begin
                illegal    = mem_we;
                misaligned = alu_out[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = 32'd0;
        if (mem_we) begin
            case (funct3[1:0])
                2'b00: begin
                    be_calc    = 4'b0001 << alu_out[1:0];
                    wdata_calc = {4{Wr_data[7:0]}};
                end
                2'b01: begin
                    be_calc    = 4'b0011 << {alu_out[1], 1'b0};
                    wdata_calc = {2{Wr_data[15:0]}};
                end
                default: begin
                    be_calc    = 4'b1111;
                    wdata_calc = Wr_data;
                end
            endcase
        end
    end

    // Lane selection uses the latched address; rdata is only valid in the ack cycle.
    always_comb begin
        rd_byte = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half = dmem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_fmt = {24'd0, rd_byte};
            3'b101:  load_fmt = {16'd0, rd_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        err_c   = 1'b0;
        done_c  = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_en) begin
                    if (misaligned || illegal) begin
                        err_c = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall_c = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                stall_c = 1'b1;
                // An ack landing on the final allowed cycle still counts as success.
                if (dmem_ack) begin
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    err_c   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                done_c  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= alu_out;
                wdata_q <= wdata_calc;
                be_q    <= be_calc;
                we_q    <= mem_we;
                f3_q    <= funct3;
            end
            if (state_q == StBusy && dmem_ack && !we_q) begin
                load_q <= load_fmt;
            end
        end
    end

    // Combinational outputs are gated by rst so they fall without waiting for clk.
    assign busy       = (state_q == StBusy);
    assign dmem_req   = busy;
    assign dmem_we    = busy & we_q;
    assign dmem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_be    = busy ? be_q : 4'd0;
    assign dmem_wdata = busy ? wdata_q : 32'd0;
    assign load_data  = load_q;
    assign stall      = stall_c & ~rst;
    assign err        = err_c & ~rst;
    assign done       = done_c & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with an arithmetic reference model of
// lane formatting, legality and timeout behaviour.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out, Wr_data, dmem_rdata;
    logic        mem_en, mem_we, dmem_ack;
    logic [2:0]  funct3;
    logic        dmem_req, dmem_we, stall, done, err;
    logic [31:0] dmem_addr, dmem_wdata, load_data;
    logic [3:0]  dmem_be;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_ld  = 32'd0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_out    (alu_out),
        .Wr_data    (Wr_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .funct3     (funct3),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .load_data  (load_data),
        .stall      (stall),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit access_ok(input logic [31:0] a, input logic [2:0] f3, input logic we);
        bit f3_ok;
        f3_ok = (f3 <= 3'd2) || ((f3 == 3'd4 || f3 == 3'd5) && !we);
        return f3_ok && ((a % access_size(f3)) == 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int unsigned off;
        off = a % 4;
        case (f3)
            3'd0, 3'd4: begin
                v = (rd >> (8 * off)) & 32'd255;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (rd >> (16 * (off / 2))) & 32'd65535;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Caller is mid-cycle (after a rising edge). ack_at > TO means memory never answers.
    task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                             input logic we, input int ack_at, input logic [31:0] rd);
        logic [3:0]  ebe;
        logic [31:0] ewd;
        int          sz;
        sz  = access_size(f3);
        ebe = 4'hF;
        ewd = 32'd0;
        if (we) begin
            if (sz == 1) begin
                ebe = 4'(1 << (a % 4));
                ewd = (d & 32'hFF) * 32'h0101_0101;
            end else if (sz == 2) begin
                ebe = 4'(3 << (a % 4));
                ewd = (d & 32'hFFFF) * 32'h0001_0001;
            end else begin
                ewd = d;
            end
        end
        mem_en = 1'b1; alu_out = a; Wr_data = d; funct3 = f3; mem_we = we;
        dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
        #1;
        if (!access_ok(a, f3, we)) begin
            check("err_bad", err, 1);
            check("stall_bad", stall, 0);
            check("req_bad", dmem_req, 0);
            @(posedge clk); #1;
            mem_en = 1'b0; dmem_ack = 1'b0;
            #1;
            check("err_once", err, 0);
            check("req_after_bad", dmem_req, 0);
            check("ld_after_bad", load_data, exp_ld);
            return;
        end
        check("stall_accept", stall, 1);
        check("err_accept", err, 0);
        check("req_accept", dmem_req, 0);
        @(posedge clk); #1;
        mem_en = 1'b0; alu_out = $urandom; Wr_data = $urandom; funct3 = 3'($urandom);
        mem_we = 1'($urandom); dmem_ack = 1'b0;
        for (int n = 1; n <= TO; n++) begin
            if (n == ack_at) begin
                dmem_ack = 1'b1; dmem_rdata = rd;
            end
            #1;
            check("req_busy", dmem_req, 1);
            check("stall_busy", stall, 1);
            check("done_busy", done, 0);
            check("addr_busy", dmem_addr, a & 32'hFFFF_FFFC);
            check("be_busy", dmem_be, ebe);
            check("we_busy", dmem_we, we);
            if (we) check("wdata_busy", dmem_wdata, ewd);
            check("err_busy", err, (n == TO && n != ack_at));
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (n == ack_at) break;
        end
        if (ack_at <= TO) begin
            if (!we) exp_ld = model_load(f3, a, rd);
            // A legal request and a stray ack during the completion cycle must be ignored.
            mem_en = 1'b1; funct3 = 3'd2; mem_we = 1'b0; alu_out = 32'h10; dmem_ack = 1'b1;
            #1;
            check("done_pulse", done, 1);
            check("stall_done", stall, 0);
            check("req_done", dmem_req, 0);
            check("err_done", err, 0);
            check("load_data", load_data, exp_ld);
            @(posedge clk); #1;
            mem_en = 1'b0; dmem_ack = 1'b0;
            #1;
            check("done_once", done, 0);
            check("req_after_done", dmem_req, 0);
            check("stall_after_done", stall, 0);
        end else begin
            #1;
            check("req_timeout", dmem_req, 0);
            check("err_timeout_once", err, 0);
            check("stall_timeout", stall, 0);
            check("done_timeout", done, 0);
            check("ld_timeout", load_data, exp_ld);
        end
    endtask

    initial begin
        rst = 1'b1; mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'd2; alu_out = 32'h0;
        Wr_data = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        #2;
        check("rst_stall", stall, 0);
        check("rst_req", dmem_req, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_ld", load_data, 0);
        check("rst_be", dmem_be, 0);
        mem_en = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        do_access(32'h1003, 32'h0, 3'd0, 1'b0, 1, 32'h80FF_1234);
        check("lb_value", load_data, 32'hFFFF_FF80);
        do_access(32'h2002, 32'h0, 3'd5, 1'b0, 1, 32'hBEEF_0000);
        check("lhu_value", load_data, 32'h0000_BEEF);
        do_access(32'h3001, 32'hA5, 3'd0, 1'b1, 2, 32'h0);
        do_access(32'h4002, 32'h0, 3'd2, 1'b0, 1, 32'h0);
        do_access(32'h4000, 32'h0, 3'd3, 1'b0, 1, 32'h0);
        do_access(32'h5000, 32'h0, 3'd2, 1'b0, TO + 1, 32'h1234_5678);
        do_access(32'h5004, 32'h0, 3'd2, 1'b0, TO, 32'hCAFE_F00D);

        // Reset between edges while BUSY.
        mem_en = 1'b1; alu_out = 32'h100; funct3 = 3'd2; mem_we = 1'b0;
        @(posedge clk); #1;
        mem_en = 1'b0;
        #1;
        check("busy_before_rst", dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_req", dmem_req, 0);
        check("midrst_stall", stall, 0);
        check("midrst_addr", dmem_addr, 0);
        check("midrst_ld", load_data, 0);
        exp_ld = 32'd0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        do_access(32'h6001, 32'h0, 3'd4, 1'b0, 1, 32'h1122_3344);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
            do_access(a, $urandom, 3'($urandom_range(0, 7)), 1'($urandom),
                      $urandom_range(1, TO + 1), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
